mac_array_ctrl: RTL and testbench
=================================

// Module: mac_array_ctrl
// PURPOSE
//  Parametrised weight-stationary MAC array: ROW x COL grid of mac_row instances plus control.
//  - Instruction skew chain is a generate-built shift register of depth ROW; the previous hand-unrolled 8-stage chain is removed.
//  - Adds a load/execute/drain tracking FSM, illegal-instruction screening and an output-psum counter.
//  - Sits between the L0/IFIFO feeders (in_w, inst_w) and the OFIFO (out_s, valid) in the core.
// PARAMETERS
//  BW       4   activation/weight bit width
//  PSUM_BW  16  partial-sum bit width
//  ROW      8   number of rows (instruction skew depth); >=1
//  COL      8   number of columns; >=1
//  CNT_W    16  width of psum_cnt
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            reset, synchronous, active-high
//  in_w       in   ROW*BW       west inputs, row r at [BW*(r+1)-1:BW*r]
//  inst_w     in   2            [1]=execute, [0]=kernel load; 2'b11 illegal
//  in_n       in   PSUM_BW*COL  north psum inputs to row 0
//  out_s      out  PSUM_BW*COL  south psum outputs of row ROW-1
//  valid      out  COL          per-column valid of row ROW-1
//  busy       out  1            FSM not in IDLE
//  load_done  out  1            COL load cycles completed since last LOAD entry
//  drain_done out  1            1-cycle pulse on DRAIN->IDLE
//  inst_err   out  1            sticky illegal/out-of-order instruction flag
//  psum_cnt   out  CNT_W        saturating count of cycles with valid[0]==1
// BEHAVIOUR
//  - Reset: skew registers, state=IDLE, counters, busy, load_done, drain_done, inst_err and psum_cnt all 0.
//  - Screening: inst_w==2'b11 sets inst_err and enters the skew chain as 2'b00.
//  - Skew: screened inst_w at cycle t reaches row r (0-based) at t+r+1; no other gating of the datapath.
//  - out_s/valid: driven combinationally by row ROW-1; both 0 after reset since all inst are 0.
//  - FSM states: IDLE, LOAD, EXEC, DRAIN; ldcnt counts up, drcnt counts down.
//    - IDLE: 01 -> LOAD, ldcnt=1. 10 -> EXEC and inst_err=1. 00 -> stay.
//    - LOAD: 01 -> ldcnt++ (saturates at COL); load_done=1 once ldcnt==COL. 00 -> stay (gaps allowed).
//      10 with ldcnt==COL -> EXEC. 10 with ldcnt<COL -> EXEC and inst_err=1.
//    - EXEC: 10 -> stay. 00 -> DRAIN, drcnt=ROW+COL-1. 01 -> LOAD, ldcnt=1, load_done=0.
//    - DRAIN: drcnt-- each cycle. At drcnt==0 -> IDLE, drain_done=1 for one cycle.
//      10 -> EXEC (drain abandoned, no pulse). 01 -> LOAD, ldcnt=1, load_done=0.
//  - load_done holds through EXEC/DRAIN/IDLE; cleared only on LOAD entry or reset.
//  - psum_cnt: +1 per cycle with valid[0]==1; holds at 2^CNT_W-1; cleared only by reset.
//  - inst_err: cleared only by reset.
//  - Reset mid-operation: all state and skew contents lost; no partial drain pulse.
// CONFIGURATION
//  MAC_ARRAY_OUT_REG_EN
//    - defined: out_s and valid registered (reset 0), adding 1 cycle of latency.
//      psum_cnt counts the registered valid[0]; the DRAIN load value becomes ROW+COL.
//    - undefined: combinational outputs, as above.
// STRUCTURE
//  - Shared package (mac_pkg): FSM state encoding (2-bit localparams) and inst opcodes INST_IDLE/LOAD/EXEC/ILLEGAL.
//  - Sub-module: existing mac_row, one instance per row via generate, with bw/psum_bw/col passed explicitly.
//  - Skew chain and FSM are inline; no new sub-module.
// TESTING (ROW=8, COL=8, BW=4, PSUM_BW=16)
//  1. Reset held 3 cycles, inst_w=01 asserted -> all outputs 0, busy=0, skew contents 0.
//  2. Skew timing: one cycle of inst_w=10 at t=0, in_n=0 -> row r sees 10 at cycle r+1.
//     Bottom valid goes nonzero no earlier than cycle 8.
//  3. Full flow: 8x inst 01 with weights 1, then 16x inst 10 with act 1, then 00.
//     - load_done=1 after the 8th load; out_s columns = 8 (sum of 8 rows x 1 x 1).
//     - drain_done pulses exactly 15 cycles after EXEC->DRAIN.
//  4. Illegal inst 11 for 1 cycle in IDLE -> inst_err=1, state stays IDLE, skew carries 00.
//     Also: 10 after only 5 loads -> inst_err=1, state EXEC.
//  5. Re-entry: inst 10 during DRAIN at drcnt=4 -> state EXEC, no drain_done.
//     Then inst 01 -> LOAD, load_done=0.
//  6. CNT_W=4: 20 cycles of valid[0]=1 -> psum_cnt saturates at 15.
//     Reset during EXEC -> psum_cnt=0, state IDLE next cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// ============================================================================
//  mac_pkg : shared FSM state encoding and instruction opcodes for the MAC array
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] inst_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_EXEC  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    localparam inst_t INST_IDLE    = 2'b00;
    localparam inst_t INST_LOAD    = 2'b01;
    localparam inst_t INST_EXEC    = 2'b10;
    localparam inst_t INST_ILLEGAL = 2'b11;

    // The illegal opcode travels down the array as a no-op.
    function automatic inst_t screen_inst(input inst_t inst);
        return (inst == INST_ILLEGAL) ? INST_IDLE : inst;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_array_ctrl_if.sv
// ============================================================================
//  mac_array_ctrl_if : feeder/OFIFO-side bundle of the MAC array controller
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mac_array_ctrl_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int CNT_W   = 16
);
    logic [ROW*BW-1:0]      in_w;
    logic [1:0]             inst_w;
    logic [PSUM_BW*COL-1:0] in_n;
    logic [PSUM_BW*COL-1:0] out_s;
    logic [COL-1:0]         valid;
    logic                   busy;
    logic                   load_done;
    logic                   drain_done;
    logic                   inst_err;
    logic [CNT_W-1:0]       psum_cnt;

    modport master (
        output in_w, inst_w, in_n,
        input  out_s, valid, busy, load_done, drain_done, inst_err, psum_cnt
    );

    modport slave (
        input  in_w, inst_w, in_n,
        output out_s, valid, busy, load_done, drain_done, inst_err, psum_cnt
    );
endinterface

`default_nettype wire

// File: rtl/mac_row.sv
// ============================================================================
//  mac_row : one row of weight-stationary MAC tiles; weights, activations and
//            instructions move east one tile per cycle, psums flow south.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mac_row #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic [bw-1:0]          in_w,
    input  wire logic [1:0]             inst_w,
    input  wire logic [psum_bw*col-1:0] in_n,
    output logic      [psum_bw*col-1:0] out_s,
    output logic      [col-1:0]         valid
);

    // Eastward forwarding registers are only needed between tiles.
    localparam int NP = (col > 1) ? col - 1 : 1;

    logic [NP-1:0][bw-1:0]       a_q, a_d;
    logic [NP-1:0]               ld_q, ld_d;
    logic [col-1:0]              ex_q, ex_d;
    logic [col-1:0][bw-1:0]      w_q, w_d;
    logic [col-1:0][psum_bw-1:0] c_q, c_d;

    logic [col-1:0][bw-1:0]      act_in;
    logic [col-1:0][bw-1:0]      w_in;
    logic [col-1:0]              ld_in;
    logic [col-1:0]              ex_in;

    always_comb begin
        act_in[0] = in_w;
        w_in[0]   = in_w;
        ld_in[0]  = inst_w[0];
        ex_in[0]  = inst_w[1];
        for (int c = 1; c < col; c++) begin
            act_in[c] = a_q[c-1];
            w_in[c]   = w_q[c-1];
            ld_in[c]  = ld_q[c-1];
            ex_in[c]  = ex_q[c-1];
        end
    end

    always_comb begin
        for (int c = 0; c < NP; c++) begin
            a_d[c]  = act_in[c];
            ld_d[c] = ld_in[c];
        end
        for (int c = 0; c < col; c++) begin
            ex_d[c] = ex_in[c];
            // Kernel load shifts the weight column east one tile per load.
            w_d[c]  = ld_in[c] ? w_in[c] : w_q[c];
            c_d[c]  = ex_in[c]
                    ? in_n[psum_bw*c +: psum_bw] + psum_bw'(act_in[c]) * psum_bw'(w_q[c])
                    : c_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            ld_q <= '0;
            ex_q <= '0;
            w_q  <= '0;
            c_q  <= '0;
        end else begin
            a_q  <= a_d;
            ld_q <= ld_d;
            ex_q <= ex_d;
            w_q  <= w_d;
            c_q  <= c_d;
        end
    end

    assign out_s = c_q;
    assign valid = ex_q;

endmodule

`default_nettype wire

// File: rtl/mac_array_ctrl.sv
// ============================================================================
//  mac_array_ctrl : ROW x COL weight-stationary MAC array with instruction skew,
//                   load/exec/drain tracking FSM, opcode screening, psum counter.
//  Option macro : MAC_ARRAY_OUT_REG_EN (registers out_s/valid, +1 cycle).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mac_array_ctrl
    import mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int CNT_W   = 16
) (
    input wire logic         clk,
    input wire logic         reset,
    mac_array_ctrl_if.slave  bus
);

`ifdef MAC_ARRAY_OUT_REG_EN
    localparam int DRAIN_LEN = ROW + COL;
`else
    localparam int DRAIN_LEN = ROW + COL - 1;
`endif
    localparam int LD_W = $clog2(COL + 1);
    localparam int DR_W = $clog2(ROW + COL + 1);
    localparam logic [LD_W-1:0] LD_FULL  = LD_W'(COL);
    localparam logic [LD_W-1:0] LD_ONE   = LD_W'(1);
    localparam logic [DR_W-1:0] DR_START = DR_W'(DRAIN_LEN);
    localparam logic [DR_W-1:0] DR_ONE   = DR_W'(1);

    inst_t                          inst_scr;
    logic [ROW-1:0][1:0]            skew;
    logic [ROW-1:0][PSUM_BW*COL-1:0] row_out;
    logic [ROW-1:0][COL-1:0]        row_valid;
    logic [PSUM_BW*COL-1:0]         out_s_w;
    logic [COL-1:0]                 valid_w;

    assign inst_scr = screen_inst(bus.inst_w);

    // ---------------- skew chain and row instances ----------------
    for (genvar r = 0; r < ROW; r++) begin : g_lane
        logic [1:0]             stg_q, stg_d;
        logic [PSUM_BW*COL-1:0] north;

        if (r == 0) begin : g_head
            always_comb stg_d = inst_scr;
            assign north = bus.in_n;
        end else begin : g_tail
            always_comb stg_d = skew[r-1];
            assign north = row_out[r-1];
        end

        always_ff @(posedge clk) begin
            if (reset) stg_q <= '0;
            else       stg_q <= stg_d;
        end

        assign skew[r] = stg_q;

        mac_row #(
            .bw      (BW),
            .psum_bw (PSUM_BW),
            .col     (COL)
        ) u_row (
            .clk    (clk),
            .reset  (reset),
            .in_w   (bus.in_w[BW*r +: BW]),
            .inst_w (stg_q),
            .in_n   (north),
            .out_s  (row_out[r]),
            .valid  (row_valid[r])
        );
    end

    // ---------------- south outputs ----------------
`ifdef MAC_ARRAY_OUT_REG_EN
    logic [PSUM_BW*COL-1:0] out_s_q, out_s_d;
    logic [COL-1:0]         valid_q, valid_d;

    always_comb begin
        out_s_d = row_out[ROW-1];
        valid_d = row_valid[ROW-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_s_q <= '0;
            valid_q <= '0;
        end else begin
            out_s_q <= out_s_d;
            valid_q <= valid_d;
        end
    end

    assign out_s_w = out_s_q;
    assign valid_w = valid_q;
`else
    assign out_s_w = row_out[ROW-1];
    assign valid_w = row_valid[ROW-1];
`endif

    assign bus.out_s = out_s_w;
    assign bus.valid = valid_w;

    // ---------------- tracking FSM ----------------
    state_t            state_q, state_d;
    logic [LD_W-1:0]   ldcnt_q, ldcnt_d;
    logic [DR_W-1:0]   drcnt_q, drcnt_d;
    logic              load_done_q, load_done_d;
    logic              drain_done_q, drain_done_d;
    logic              inst_err_q, inst_err_d;
    logic [CNT_W-1:0]  psum_cnt_q, psum_cnt_d;
    logic              busy_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ldcnt_q      <= '0;
            drcnt_q      <= '0;
            load_done_q  <= 1'b0;
            drain_done_q <= 1'b0;
            inst_err_q   <= 1'b0;
            psum_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ldcnt_q      <= ldcnt_d;
            drcnt_q      <= drcnt_d;
            load_done_q  <= load_done_d;
            drain_done_q <= drain_done_d;
            inst_err_q   <= inst_err_d;
            psum_cnt_q   <= psum_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ldcnt_d      = ldcnt_q;
        drcnt_d      = drcnt_q;
        load_done_d  = load_done_q;
        drain_done_d = 1'b0;
        inst_err_d   = inst_err_q | (bus.inst_w == INST_ILLEGAL);

        case (state_q)
            ST_IDLE: begin
                if (inst_scr == INST_LOAD) begin
                    state_d     = ST_LOAD;
                    ldcnt_d     = LD_ONE;
                    load_done_d = (LD_ONE == LD_FULL);
                end else if (inst_scr == INST_EXEC) begin
                    state_d    = ST_EXEC;
                    inst_err_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (inst_scr == INST_LOAD) begin
                    if (ldcnt_q != LD_FULL) ldcnt_d = ldcnt_q + LD_ONE;
                    if (ldcnt_d == LD_FULL) load_done_d = 1'b1;
                end else if (inst_scr == INST_EXEC) begin
                    state_d = ST_EXEC;
                    if (ldcnt_q != LD_FULL) inst_err_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (inst_scr == INST_IDLE) begin
                    state_d = ST_DRAIN;
                    drcnt_d = DR_START;
                end else if (inst_scr == INST_LOAD) begin
                    state_d     = ST_LOAD;
                    ldcnt_d     = LD_ONE;
                    load_done_d = (LD_ONE == LD_FULL);
                end
            end
            ST_DRAIN: begin
                if (inst_scr == INST_EXEC) begin
                    state_d = ST_EXEC;
                end else if (inst_scr == INST_LOAD) begin
                    state_d     = ST_LOAD;
                    ldcnt_d     = LD_ONE;
                    load_done_d = (LD_ONE == LD_FULL);
                end else if (drcnt_q <= DR_ONE) begin
                    // Count reaches zero on this edge: leave and pulse.
                    state_d      = ST_IDLE;
                    drcnt_d      = '0;
                    drain_done_d = 1'b1;
                end else begin
                    drcnt_d = drcnt_q - DR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_w = (state_q != ST_IDLE);
    end

    always_comb begin
        psum_cnt_d = psum_cnt_q;
        if (valid_w[0] && (psum_cnt_q != {CNT_W{1'b1}}))
            psum_cnt_d = psum_cnt_q + CNT_W'(1);
    end

    assign bus.busy       = busy_w;
    assign bus.load_done  = load_done_q;
    assign bus.drain_done = drain_done_q;
    assign bus.inst_err   = inst_err_q;
    assign bus.psum_cnt   = psum_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_array_ctrl.sv
// ============================================================================
//  tb_mac_array_ctrl : directed checks of skew, FSM, screening and psum count
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_array_ctrl;
    import mac_pkg::*;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int ROW     = 8;
    localparam int COL     = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_array_ctrl_if #(.BW(BW), .PSUM_BW(PSUM_BW), .ROW(ROW), .COL(COL), .CNT_W(16)) bus ();
    mac_array_ctrl_if #(.BW(BW), .PSUM_BW(PSUM_BW), .ROW(ROW), .COL(COL), .CNT_W(4))  bus4 ();

    assign bus4.in_w   = bus.in_w;
    assign bus4.inst_w = bus.inst_w;
    assign bus4.in_n   = bus.in_n;

    mac_array_ctrl #(.BW(BW), .PSUM_BW(PSUM_BW), .ROW(ROW), .COL(COL), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mac_array_ctrl #(.BW(BW), .PSUM_BW(PSUM_BW), .ROW(ROW), .COL(COL), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] inst, input int n);
        bus.inst_w = inst;
        tick(n);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.inst_w = 2'b00;
        tick(1);
        reset      = 1'b0;
    endtask

    logic [2*ROW-1:0]       exp_sk;
    logic [PSUM_BW*COL-1:0] exp_out;
    int                     early;

    initial begin
        reset      = 1'b1;
        bus.in_w   = '0;
        bus.in_n   = '0;
        bus.inst_w = 2'b01;

        // 1. reset held 3 cycles with a load instruction present
        tick(3);
        check_val("rst_busy",       bus.busy,       0);
        check_val("rst_out_s",      bus.out_s,      0);
        check_val("rst_valid",      bus.valid,      0);
        check_val("rst_load_done",  bus.load_done,  0);
        check_val("rst_drain_done", bus.drain_done, 0);
        check_val("rst_inst_err",   bus.inst_err,   0);
        check_val("rst_psum_cnt",   bus.psum_cnt,   0);
        check_val("rst_skew",       dut.skew,       0);
        bus.inst_w = 2'b00;
        reset      = 1'b0;

        // 2. single execute token walks down the skew chain
        drive(2'b10, 1);
        check_val("skew_err_idle_exec", bus.inst_err, 1);
        bus.inst_w = 2'b00;
        for (int k = 1; k <= ROW; k++) begin
            if (k > 1) tick(1);
            exp_sk = '0;
            exp_sk[2*(k-1) +: 2] = 2'b10;
            check_val($sformatf("skew_row%0d", k-1), dut.skew, exp_sk);
            check_val($sformatf("skew_valid_c%0d", k), bus.valid, 0);
        end
        tick(1);
        check_val("skew_valid_first", bus.valid, 8'h01);
        check_val("skew_empty",       dut.skew,  0);

        // 3. full load / execute / drain flow with unit weights and activations
        do_reset();
        bus.in_w = {ROW{4'h1}};
        for (int i = 0; i < COL; i++) begin
            drive(2'b01, 1);
            if (i == COL-2) check_val("flow_load_done_7", bus.load_done, 0);
        end
        check_val("flow_load_done_8", bus.load_done, 1);
        check_val("flow_busy_load",   bus.busy,      1);
        drive(2'b10, 16);
        check_val("flow_state_exec", dut.state_q, ST_EXEC);
        drive(2'b00, 1);
        check_val("flow_state_drain", dut.state_q, ST_DRAIN);
        check_val("flow_valid_all",   bus.valid,   8'hFF);
        exp_out = {COL{16'd8}};
        check_val("flow_out_s",       bus.out_s,   exp_out);
        early = 0;
        for (int j = 1; j <= 14; j++) begin
            tick(1);
            if (bus.drain_done) early++;
        end
        check_val("flow_drain_early", early, 0);
        tick(1);
        check_val("flow_drain_pulse", bus.drain_done, 1);
        check_val("flow_idle_busy",   bus.busy,       0);
        tick(1);
        check_val("flow_drain_1cyc",  bus.drain_done, 0);
        check_val("flow_psum_cnt",    bus.psum_cnt,   16);
        check_val("flow_psum_cnt4",   bus4.psum_cnt,  15);
        check_val("flow_load_hold",   bus.load_done,  1);
        check_val("flow_no_err",      bus.inst_err,   0);

        // 4. illegal opcode in IDLE, then premature execute
        do_reset();
        drive(2'b11, 1);
        check_val("ill_err",  bus.inst_err, 1);
        check_val("ill_busy", bus.busy,     0);
        check_val("ill_skew", dut.skew,     0);
        do_reset();
        check_val("ill_err_cleared", bus.inst_err, 0);
        drive(2'b01, 5);
        check_val("early_no_err", bus.inst_err, 0);
        drive(2'b10, 1);
        check_val("early_err",       bus.inst_err,  1);
        check_val("early_state",     dut.state_q,   ST_EXEC);
        check_val("early_load_done", bus.load_done, 0);

        // 5. abandon a drain, then reload
        do_reset();
        drive(2'b01, COL);
        drive(2'b10, 3);
        drive(2'b00, 1);
        check_val("re_drcnt_start", dut.drcnt_q, 15);
        tick(11);
        check_val("re_drcnt_4", dut.drcnt_q, 4);
        drive(2'b10, 1);
        check_val("re_state_exec", dut.state_q,    ST_EXEC);
        check_val("re_no_pulse",   bus.drain_done, 0);
        check_val("re_load_hold",  bus.load_done,  1);
        drive(2'b01, 1);
        check_val("re_state_load", dut.state_q,   ST_LOAD);
        check_val("re_load_clr",   bus.load_done, 0);

        // 6. counter saturation, then reset in the middle of execution
        do_reset();
        drive(2'b01, COL);
        drive(2'b10, 20);
        drive(2'b00, 40);
        check_val("sat_cnt16", bus.psum_cnt,  20);
        check_val("sat_cnt4",  bus4.psum_cnt, 15);
        do_reset();
        drive(2'b01, COL);
        drive(2'b10, 12);
        check_val("mid_cnt_before", bus.psum_cnt, 3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_val("mid_cnt_cleared",  bus.psum_cnt,   0);
        check_val("mid_cnt4_cleared", bus4.psum_cnt,  0);
        check_val("mid_state_idle",   dut.state_q,    ST_IDLE);
        check_val("mid_busy",         bus.busy,       0);
        check_val("mid_valid",        bus.valid,      0);
        check_val("mid_no_pulse",     bus.drain_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
